// File: rtl/img_filter_pkg.sv
// Shared types and sizes for the image filter line buffers.
// State encoding and pixel/line geometry.
package img_filter_pkg;

  localparam int PIX_W    = 24;
  localparam int LINE_MAX = 2048;
  localparam int COL_W    = $clog2(LINE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } ld_state_t;

endpackage

// File: rtl/line_delay_ctrl.sv
// One-line delay sequencer around a 2048x24 sync FIFO.
// Pairs each pixel with the same column of the previous line.
module line_delay_ctrl
  import img_filter_pkg::*;
#(
  parameter int IMG_WIDTH = 1920,
  parameter int FLUSH_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_cur,
  output logic [PIX_W-1:0] out_prev,
  output logic             out_prev_vld,
  output logic             out_eol,
  output logic             fifo_rst,
  output logic             fifo_wr_en,
  output logic [PIX_W-1:0] fifo_wr_data,
  output logic             fifo_rd_en,
  input  logic [PIX_W-1:0] fifo_rd_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [COL_W-1:0] COL_LAST =
    COL_W'(IMG_WIDTH - 1);
  localparam logic [3:0] FL_LAST =
    4'(FLUSH_CYC - 1);

  ld_state_t        state;
  ld_state_t        state_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic [3:0]       fcnt;
  logic [3:0]       fcnt_nxt;
  logic             last_col;
  logic             accept;
  logic             rd_req;
  logic             ovf_hit;
  logic             unf_hit;

  assign last_col = (col == COL_LAST);

  // Next state, column and flush count; decides pixel acceptance.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    fcnt_nxt  = fcnt;
    accept    = 1'b0;
    rd_req    = 1'b0;
    if (frame_start) begin
      state_nxt = FLUSH;
      col_nxt   = '0;
      fcnt_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        FLUSH: begin
          if (fcnt == FL_LAST) begin
            state_nxt = PRIME;
          end else begin
            fcnt_nxt = fcnt + 4'd1;
          end
        end
        PRIME: begin
          if (in_valid) begin
            accept = 1'b1;
            if (last_col) begin
              col_nxt   = '0;
              state_nxt = RUN;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            accept = 1'b1;
            rd_req = 1'b1;
            if (last_col) begin
              col_nxt = '0;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign fifo_wr_en   = accept & ~fifo_full;
  assign fifo_rd_en   = rd_req & ~fifo_empty;
  assign fifo_wr_data = in_data;
  assign out_prev     = fifo_rd_data;
  assign ovf_hit      = accept & fifo_full;
  assign unf_hit      = rd_req & fifo_empty;

  // State, column and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Output pixel stage, one cycle behind the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_cur      <= '0;
      out_eol      <= 1'b0;
      out_prev_vld <= 1'b0;
      fifo_rst     <= 1'b0;
    end else begin
      out_valid    <= accept;
      out_eol      <= accept & last_col;
      out_prev_vld <= fifo_rd_en;
      fifo_rst     <= (state_nxt == FLUSH);
      if (accept) begin
        out_cur <= in_data;
      end
    end
  end

  // Sticky error flags, cleared by a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (frame_start) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (ovf_hit) begin
        err_ovf <= 1'b1;
      end
      if (unf_hit) begin
        err_unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Bench for line_delay_ctrl with a behavioural FIFO and a
// pixel-history reference model.
module tb_line_delay_ctrl;

  localparam int W = 8;
  localparam int F = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic [23:0] out_cur;
  logic [23:0] out_prev;
  logic        out_prev_vld;
  logic        out_eol;
  logic        fifo_rst;
  logic        fifo_wr_en;
  logic [23:0] fifo_wr_data;
  logic        fifo_rd_en;
  logic [23:0] fifo_rd_data = '0;
  logic        fifo_full;
  logic        fifo_empty;
  logic        err_ovf;
  logic        err_unf;

  logic force_e = 1'b0;
  logic force_f = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  line_delay_ctrl #(.IMG_WIDTH(W), .FLUSH_CYC(F)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_cur(out_cur),
    .out_prev(out_prev), .out_prev_vld(out_prev_vld),
    .out_eol(out_eol), .fifo_rst(fifo_rst),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // Behavioural 2048-deep FIFO, 1-cycle read latency.
  logic [23:0] fq[$];
  int occ = 0;
  always @(posedge clk) begin
    if (fifo_rst) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0)
        fifo_rd_data <= fq.pop_front();
      if (fifo_wr_en) fq.push_back(fifo_wr_data);
    end
    occ = fq.size();
  end
  assign fifo_empty = force_e | (occ == 0);
  assign fifo_full  = force_f | (occ >= 2048);

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] cur;
    logic [23:0] prev;
    logic        pv;
    logic        eol;
  } ent_t;
  ent_t lg[$];

  // Reference model: frame pixel history and counts.
  bit          in_frame = 0;
  int          flush_left = 0;
  int          n_acc = 0;
  bit          dirty = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;
  bit          e_ov = 0;
  bit          e_eol = 0;
  bit          e_pv = 0;
  bit          e_pchk = 0;
  logic [23:0] e_cur = '0;
  logic [23:0] e_prev = '0;
  logic [23:0] hist[$];

  // Compares DUT against the model once per cycle, just
  // before the rising edge.
  always begin
    bit acc;
    bit rdq;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      chk("rst out_valid", out_valid, 0);
      chk("rst out_prev_vld", out_prev_vld, 0);
      chk("rst out_eol", out_eol, 0);
      chk("rst out_cur", out_cur, 0);
      chk("rst fifo_rst", fifo_rst, 0);
      chk("rst wr_en", fifo_wr_en, 0);
      chk("rst rd_en", fifo_rd_en, 0);
      chk("rst err_ovf", err_ovf, 0);
      chk("rst err_unf", err_unf, 0);
      in_frame = 0; flush_left = 0; n_acc = 0;
      dirty = 0; m_ovf = 0; m_unf = 0;
      e_ov = 0; e_eol = 0; e_pv = 0;
      e_cur = '0; hist.delete();
    end else begin
      chk("out_valid", out_valid, e_ov);
      chk("out_eol", out_eol, e_eol);
      chk("out_prev_vld", out_prev_vld, e_pv);
      if (e_ov) chk("out_cur", out_cur, e_cur);
      if (e_pv && e_pchk) chk("out_prev", out_prev, e_prev);
      chk("fifo_rst", fifo_rst, flush_left > 0);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_unf", err_unf, m_unf);
      if (out_valid)
        lg.push_back('{out_cur, out_prev, out_prev_vld,
                       out_eol});
      acc = in_frame && flush_left == 0 && in_valid &&
            !frame_start;
      rdq = acc && n_acc >= W;
      chk("fifo_wr_en", fifo_wr_en, acc && !fifo_full);
      chk("fifo_rd_en", fifo_rd_en, rdq && !fifo_empty);
      chk("fifo_wr_data", fifo_wr_data, in_data);
      e_ov = 0; e_eol = 0; e_pv = 0; e_pchk = 0;
      if (frame_start) begin
        in_frame = 1; flush_left = F; n_acc = 0;
        dirty = 0; m_ovf = 0; m_unf = 0;
        hist.delete();
      end else begin
        if (flush_left > 0) flush_left--;
        if (acc) begin
          e_ov  = 1;
          e_cur = in_data;
          e_eol = (n_acc % W) == W - 1;
          e_pv  = rdq && !fifo_empty;
          if (e_pv) begin
            e_prev = hist[n_acc - W];
            e_pchk = !dirty;
          end
          if (fifo_full) begin
            dirty = 1; m_ovf = 1;
          end
          if (rdq && fifo_empty) begin
            dirty = 1; m_unf = 1;
          end
          hist.push_back(in_data);
          n_acc++;
        end
      end
    end
  end

  task automatic px(logic [23:0] d, bit fe = 0,
                    bit ff = 0);
    @(negedge clk);
    frame_start = 0; in_valid = 1; in_data = d;
    force_e = fe; force_f = ff;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      frame_start = 0; in_valid = 0;
      force_e = 0; force_f = 0;
    end
  endtask

  task automatic fs(bit v = 0, logic [23:0] d = '0);
    @(negedge clk);
    frame_start = 1; in_valid = v; in_data = d;
    force_e = 0; force_f = 0;
  endtask

  function automatic int eol_cnt();
    int n = 0;
    foreach (lg[i]) if (lg[i].eol) n++;
    return n;
  endfunction

  initial begin
    int rc;
    int pv0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    // IDLE ignores pixels
    px(24'h999); px(24'h998); idle(1);

    // flush length
    fs();
    rc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      frame_start = 0;
      #2;
      if (fifo_rst) rc++;
    end
    chk("flush cycles", rc, 4);

    // two clean lines
    lg.delete();
    for (int c = 0; c < W; c++) px(24'(c));
    for (int c = 0; c < W; c++) px(24'h100 + 24'(c));
    idle(2);
    chk("log size l01", lg.size(), 16);
    pv0 = 0;
    for (int i = 0; i < W; i++) pv0 += int'(lg[i].pv);
    chk("line0 prev_vld", pv0, 0);
    chk("l1c3 cur", lg[11].cur, 24'h000103);
    chk("l1c3 prev", lg[11].prev, 24'h000003);
    chk("l1c3 pv", lg[11].pv, 1);
    chk("eol col7", lg[7].eol, 1);
    chk("eol col15", lg[15].eol, 1);
    chk("eol count", eol_cnt(), 2);

    // random gaps over 4 lines
    fs(); idle(F);
    lg.delete();
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(0, 1) == 1) idle(1);
        px({8'h00, 8'(l), 8'(c)});
      end
    idle(2);
    chk("gap log size", lg.size(), 32);
    chk("gap last cur", lg[31].cur, 24'h000307);
    chk("gap last prev", lg[31].prev, 24'h000207);
    chk("gap err_ovf", err_ovf, 0);
    chk("gap err_unf", err_unf, 0);

    // underflow at line 1 column 3
    fs(); idle(F);
    lg.delete();
    for (int c = 0; c < W; c++) px(24'h10 + 24'(c));
    for (int c = 0; c < W; c++)
      px(24'h110 + 24'(c), c == 3);
    idle(2);
    chk("unf flag", err_unf, 1);
    chk("unf pixel pv", lg[11].pv, 0);
    chk("unf next pv", lg[12].pv, 1);
    fs(); idle(1);
    #2;
    chk("unf cleared", err_unf, 0);

    // overflow while priming
    idle(F - 1);
    for (int c = 0; c < W; c++)
      px(24'h20 + 24'(c), 0, c == 2);
    idle(1);
    #2;
    chk("ovf flag", err_ovf, 1);

    // frame_start with a pixel mid-RUN
    fs(); idle(F);
    for (int c = 0; c < W; c++) px(24'h30 + 24'(c));
    for (int c = 0; c < 4; c++) px(24'h130 + 24'(c));
    fs(1, 24'hbad);
    idle(1);
    lg.delete();
    idle(F - 1);
    for (int c = 0; c < W; c++) px(24'h40 + 24'(c));
    idle(2);
    chk("restart size", lg.size(), W);
    chk("restart cur0", lg[0].cur, 24'h000040);
    chk("restart pv0", lg[0].pv, 0);
    chk("restart eol7", lg[W-1].eol, 1);
    chk("restart eols", eol_cnt(), 1);

    // reset mid-RUN
    for (int c = 0; c < 3; c++) px(24'h140 + 24'(c));
    @(negedge clk);
    rst_n = 0; in_valid = 1; in_data = 24'h55;
    #2;
    chk("arst out_valid", out_valid, 0);
    chk("arst wr_en", fifo_wr_en, 0);
    chk("arst rd_en", fifo_rd_en, 0);
    idle(2);
    rst_n = 1;
    px(24'h77); px(24'h78); idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
